per2axi_resp_arbiter: RTL and testbench

//  Response-side stage of the peripheral-to-AXI bridge. Sits downstream of the

---
 rtl/per2axi_resp_arbiter.sv | 92 +++++++++
 tb/tb_per2axi_resp_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/per2axi_resp_arbiter.sv
// rtl/per2axi_resp_arbiter.sv - merges AXI R/B responses into the single-beat peripheral response port
// Fair R/B arbitration with a per-ID table that selects the 32-bit half of each 64-bit read beat.
module per2axi_resp_arbiter #(
  parameter int NB_CORES       = 4,
  parameter int PER_ID_WIDTH   = 5,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_USER_WIDTH = 6,
  parameter int AXI_ID_WIDTH   = 3
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  output logic                      per_slave_r_valid_o,
  output logic                      per_slave_r_opc_o,
  output logic [PER_ID_WIDTH-1:0]   per_slave_r_id_o,
  output logic [31:0]               per_slave_r_rdata_o,
  input  logic                      axi_master_r_valid_i,
  input  logic [AXI_DATA_WIDTH-1:0] axi_master_r_data_i,
  input  logic [1:0]                axi_master_r_resp_i,
  input  logic                      axi_master_r_last_i,
  input  logic [AXI_ID_WIDTH-1:0]   axi_master_r_id_i,
  input  logic [AXI_USER_WIDTH-1:0] axi_master_r_user_i,
  output logic                      axi_master_r_ready_o,
  input  logic                      axi_master_b_valid_i,
  input  logic [1:0]                axi_master_b_resp_i,
  input  logic [AXI_ID_WIDTH-1:0]   axi_master_b_id_i,
  input  logic [AXI_USER_WIDTH-1:0] axi_master_b_user_i,
  output logic                      axi_master_b_ready_o,
  input  logic                      trans_req_i,
  input  logic [AXI_ID_WIDTH-1:0]   trans_id_i,
  input  logic [AXI_ADDR_WIDTH-1:0] trans_add_i
);

  localparam int NUM_IDS = 2 ** AXI_ID_WIDTH;
  localparam int unused_nb_cores = NB_CORES;

  logic [NUM_IDS-1:0] pending_q;
  logic [NUM_IDS-1:0] hi_q;
  logic               prio_q;
  logic               grant_r;
  logic               grant_b;
  logic               unused_ok;

  function automatic logic [PER_ID_WIDTH-1:0] id_onehot(input logic [AXI_ID_WIDTH-1:0] id);
    id_onehot = '0;
    for (int i = 0; i < PER_ID_WIDTH; i++) begin
      if (int'(id) == i) id_onehot[i] = 1'b1;
    end
  endfunction

  // prio only matters when both channels are valid; 0 favours R.
  assign grant_r = !rst_i && axi_master_r_valid_i && (!axi_master_b_valid_i || !prio_q);
  assign grant_b = !rst_i && axi_master_b_valid_i && (!axi_master_r_valid_i || prio_q);

  assign axi_master_r_ready_o = grant_r;
  assign axi_master_b_ready_o = grant_b;

  assign unused_ok = ^{pending_q, axi_master_r_last_i, axi_master_r_user_i,
                       axi_master_b_user_i, trans_add_i};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q           <= '0;
      hi_q                <= '0;
      prio_q              <= 1'b0;
      per_slave_r_valid_o <= 1'b0;
      per_slave_r_opc_o   <= 1'b0;
      per_slave_r_id_o    <= '0;
      per_slave_r_rdata_o <= '0;
    end else begin
      per_slave_r_valid_o <= grant_r | grant_b;
      if (grant_r) begin
        pending_q[axi_master_r_id_i] <= 1'b0;
        per_slave_r_rdata_o <= hi_q[axi_master_r_id_i] ? axi_master_r_data_i[63:32]
                                                       : axi_master_r_data_i[31:0];
        per_slave_r_opc_o   <= axi_master_r_resp_i[1];
        per_slave_r_id_o    <= id_onehot(axi_master_r_id_i);
      end else if (grant_b) begin
        per_slave_r_rdata_o <= '0;
        per_slave_r_opc_o   <= axi_master_b_resp_i[1];
        per_slave_r_id_o    <= id_onehot(axi_master_b_id_i);
      end
      // Placed after the R clear so a same-ID issue in the same cycle re-arms the entry.
      if (trans_req_i) begin
        pending_q[trans_id_i] <= 1'b1;
        hi_q[trans_id_i]      <= trans_add_i[2];
      end
      if (axi_master_r_valid_i && axi_master_b_valid_i) prio_q <= ~prio_q;
    end
  end

endmodule

// File: tb/tb_per2axi_resp_arbiter.sv
// tb/tb_per2axi_resp_arbiter.sv - self-checking bench for per2axi_resp_arbiter
// Directed scenarios plus randomized traffic checked against a behavioural model.
module tb_per2axi_resp_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        p_valid, p_opc;
  logic [4:0]  p_id;
  logic [31:0] p_rdata;
  logic        r_valid, r_last, r_ready;
  logic [63:0] r_data;
  logic [1:0]  r_resp, b_resp;
  logic [2:0]  r_id, b_id, t_id;
  logic [5:0]  r_user, b_user;
  logic        b_valid, b_ready, t_req;
  logic [31:0] t_add;

  int checks = 0;
  int failures = 0;

  // Behavioural model state
  logic        m_hi [8];
  logic        m_prio;
  logic        e_valid, e_opc;
  logic [4:0]  e_id;
  logic [31:0] e_rdata;
  logic        last_gr;

  always #5 clk = ~clk;

  per2axi_resp_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .per_slave_r_valid_o(p_valid), .per_slave_r_opc_o(p_opc),
    .per_slave_r_id_o(p_id), .per_slave_r_rdata_o(p_rdata),
    .axi_master_r_valid_i(r_valid), .axi_master_r_data_i(r_data),
    .axi_master_r_resp_i(r_resp), .axi_master_r_last_i(r_last),
    .axi_master_r_id_i(r_id), .axi_master_r_user_i(r_user),
    .axi_master_r_ready_o(r_ready),
    .axi_master_b_valid_i(b_valid), .axi_master_b_resp_i(b_resp),
    .axi_master_b_id_i(b_id), .axi_master_b_user_i(b_user),
    .axi_master_b_ready_o(b_ready),
    .trans_req_i(t_req), .trans_id_i(t_id), .trans_add_i(t_add)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] onehot(input logic [2:0] id);
    return (id < 5) ? (5'd1 << id) : 5'd0;
  endfunction

  task automatic idle_inputs();
    rst = 0; r_valid = 0; b_valid = 0; t_req = 0;
    r_data = '0; r_resp = 0; r_id = 0; b_resp = 0; b_id = 0; t_id = 0; t_add = 0;
    r_last = 1; r_user = '0; b_user = '0;
  endtask

  // Called at a negedge with inputs already set; returns at the next negedge
  // after comparing readies and the registered response with the model.
  task automatic step();
    logic gr, gb;
    #1;
    gr = !rst && r_valid && (!b_valid || !m_prio);
    gb = !rst && b_valid && (!r_valid || m_prio);
    last_gr = gr;
    chk("r_ready", r_ready, gr);
    chk("b_ready", b_ready, gb);
    chk("ready_exclusive", r_ready & b_ready, 0);
    if (rst) begin
      foreach (m_hi[i]) m_hi[i] = 0;
      m_prio = 0;
      e_valid = 0; e_opc = 0; e_id = 0; e_rdata = 0;
    end else begin
      e_valid = gr | gb;
      if (gr) begin
        e_rdata = m_hi[r_id] ? r_data[63:32] : r_data[31:0];
        e_opc   = r_resp[1];
        e_id    = onehot(r_id);
      end else if (gb) begin
        e_rdata = 0;
        e_opc   = b_resp[1];
        e_id    = onehot(b_id);
      end
      if (t_req) m_hi[t_id] = t_add[2];
      if (r_valid && b_valid) m_prio = ~m_prio;
    end
    @(negedge clk);
    chk("valid", p_valid, e_valid);
    chk("rdata", p_rdata, e_rdata);
    chk("opc", p_opc, e_opc);
    chk("id", p_id, e_id);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    step();
    rst = 0;
  endtask

  initial begin
    logic [3:0] pat;
    idle_inputs();
    foreach (m_hi[i]) m_hi[i] = 0;
    m_prio = 0; e_valid = 0; e_opc = 0; e_id = 0; e_rdata = 0;
    @(negedge clk);
    do_reset();
    chk("reset_valid", p_valid, 0);
    chk("reset_rdata", p_rdata, 0);
    chk("reset_id", p_id, 0);

    // 1: upper half selected by add[2]
    t_req = 1; t_id = 2; t_add = 32'h1004; step(); t_req = 0;
    r_valid = 1; r_id = 2; r_data = 64'hAAAA_BBBB_CCCC_DDDD; r_resp = 0; step(); r_valid = 0;
    chk("t1_valid", p_valid, 1);
    chk("t1_rdata", p_rdata, 32'hAAAABBBB);
    chk("t1_id", p_id, 5'b00100);
    chk("t1_opc", p_opc, 0);
    step();
    chk("t1_single_pulse", p_valid, 0);

    // 2: lower half with error response
    t_req = 1; t_id = 1; t_add = 32'h1000; step(); t_req = 0;
    r_valid = 1; r_id = 1; r_data = 64'h1111_2222_3333_4444; r_resp = 2'b10; step(); r_valid = 0;
    chk("t2_rdata", p_rdata, 32'h33334444);
    chk("t2_opc", p_opc, 1);
    chk("t2_id", p_id, 5'b00010);

    // 3: contested R/B alternate starting with R after reset
    do_reset();
    r_valid = 1; r_id = 0; r_data = 64'h5555_6666_7777_8888; r_resp = 0;
    b_valid = 1; b_id = 4; b_resp = 0;
    pat = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      step();
      pat[i] = last_gr;
      chk("t3_pulse", p_valid, 1);
      if (i % 2 == 1) chk("t3_b_rdata", p_rdata, 0);
    end
    chk("t3_grant_order", pat, 4'b0101);
    r_valid = 0; b_valid = 0; step();
    chk("t3_after", p_valid, 0);

    // 4: same-cycle issue and R on ID 3: R uses the old hi bit
    t_req = 1; t_id = 3; t_add = 32'h4; step();
    t_add = 32'h0; r_valid = 1; r_id = 3; r_data = 64'hDEAD_BEEF_0123_4567; r_resp = 0; step();
    t_req = 0;
    chk("t4_old_hi", p_rdata, 32'hDEADBEEF);
    step(); r_valid = 0;
    chk("t4_new_hi", p_rdata, 32'h01234567);

    // 5: B with an ID beyond the one-hot width
    b_valid = 1; b_id = 6; b_resp = 0; step(); b_valid = 0;
    chk("t5_valid", p_valid, 1);
    chk("t5_id", p_id, 0);
    chk("t5_rdata", p_rdata, 0);

    // 6: reset right after a handshake clears the output and the table
    t_req = 1; t_id = 5; t_add = 32'h4; step(); t_req = 0;
    r_valid = 1; r_id = 5; r_data = 64'h9999_AAAA_BBBB_CCCC; step(); r_valid = 0;
    rst = 1; step(); rst = 0;
    chk("t6_valid", p_valid, 0);
    chk("t6_rdata", p_rdata, 0);
    r_valid = 1; r_id = 5; b_valid = 1; b_id = 0; step(); r_valid = 0; b_valid = 0;
    chk("t6_hi_cleared", p_rdata, 32'hBBBBCCCC);
    chk("t6_prio_r_first", last_gr, 1);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      rst     = ($urandom_range(0, 63) == 0);
      r_valid = $urandom_range(0, 1);
      r_data  = {$urandom, $urandom};
      r_resp  = 2'($urandom);
      r_id    = 3'($urandom);
      r_user  = 6'($urandom);
      b_valid = $urandom_range(0, 1);
      b_resp  = 2'($urandom);
      b_id    = 3'($urandom);
      b_user  = 6'($urandom);
      t_req   = $urandom_range(0, 1);
      t_id    = 3'($urandom);
      t_add   = $urandom;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
